// File: rtl/vga_up_dxdy_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_up_dxdy_if
// Purpose  : Output beat stream of the 960x540 -> 1280x720 coordinate and
//            bilinear-coefficient generator (valid/ready handshake).
// Signals  : out_vld/out_rdy handshake; src_x/src_y integer source pixel;
//            dx/dy 5-bit fractions and their product dxy; x_edge/y_edge
//            last source column/row; out_eol/out_eof line/frame markers.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_up_dxdy_if;
  logic        out_vld;
  logic        out_rdy;
  logic [10:0] src_x;
  logic [9:0]  src_y;
  logic [4:0]  dx;
  logic [4:0]  dy;
  logic [9:0]  dxy;
  logic        x_edge;
  logic        y_edge;
  logic        out_eol;
  logic        out_eof;

  // Generator side drives the beat and samples ready.
  modport master (
    output out_vld, src_x, src_y, dx, dy, dxy, x_edge, y_edge, out_eol, out_eof,
    input  out_rdy
  );

  // Consumer side (frame-buffer reader / interpolator).
  modport slave (
    input  out_vld, src_x, src_y, dx, dy, dxy, x_edge, y_edge, out_eol, out_eof,
    output out_rdy
  );
endinterface
`default_nettype wire

// File: rtl/vga_up_dxdy.sv
`default_nettype none
// ============================================================================
// Module   : vga_up_dxdy
// Purpose  : Per-destination-pixel source coordinate and bilinear weight
//            generator for the 960x540 -> 1280x720 upscale. Emits one beat
//            per destination pixel in raster order over a valid/ready stream.
// Ports    : clk          system clock
//            rst          asynchronous, active-high reset
//            start_i      frame start pulse (ignored unless idle)
//            busy_o       high while a frame is being generated
//            frame_done_o one-cycle pulse after the last beat transfers
//            out_if       beat stream (vga_up_dxdy_if.master)
// Revision : 1.0 - initial release
// ============================================================================
module vga_up_dxdy #(
  parameter int DST_W  = 1280,
  parameter int DST_H  = 720,
  parameter int SRC_W  = 960,
  parameter int SRC_H  = 540,
  parameter int STEP_X = (32 * SRC_W) / DST_W,
  parameter int STEP_Y = (32 * SRC_H) / DST_H
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start_i,
  output logic               busy_o,
  output logic               frame_done_o,
  vga_up_dxdy_if.master      out_if
);

  // Pixel centres are aligned: s = STEP*dst + STEP/2 - 16 (1/32 units).
  localparam logic signed [15:0] c_ACC_X0  = 16'(STEP_X / 2 - 16);
  localparam logic signed [15:0] c_ACC_Y0  = 16'(STEP_Y / 2 - 16);
  localparam logic signed [15:0] c_STEP_X  = 16'(STEP_X);
  localparam logic signed [15:0] c_STEP_Y  = 16'(STEP_Y);
  localparam logic [10:0]        c_LAST_X  = 11'(DST_W - 1);
  localparam logic [9:0]         c_LAST_Y  = 10'(DST_H - 1);
  localparam logic [10:0]        c_EDGE_X  = 11'(SRC_W - 1);
  localparam logic [9:0]         c_EDGE_Y  = 10'(SRC_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [10:0]        dst_x_q, dst_x_d;
  logic [9:0]         dst_y_q, dst_y_d;
  logic signed [15:0] acc_x_q, acc_x_d;
  logic signed [15:0] acc_y_q, acc_y_d;

  // Registered beat fields (the values currently presented downstream).
  logic               vld_q,    vld_d;
  logic [10:0]        src_x_q,  src_x_d;
  logic [9:0]         src_y_q,  src_y_d;
  logic [4:0]         dx_q,     dx_d;
  logic [4:0]         dy_q,     dy_d;
  logic [9:0]         dxy_q,    dxy_d;
  logic               x_edge_q, x_edge_d;
  logic               y_edge_q, y_edge_d;
  logic               eol_q,    eol_d;
  logic               eof_q,    eof_d;

  logic               w_fire;
  logic               w_load;   // register a fresh beat from the *_d position
  logic               w_clear;  // frame finished: drop valid, zero the fields
  logic               w_x_neg;
  logic               w_y_neg;
  logic [10:0]        w_src_x;
  logic [9:0]         w_src_y;
  logic [4:0]         w_dx;
  logic [4:0]         w_dy;

  assign w_fire = vld_q & out_if.out_rdy;

  // --------------------------------------------------------------------------
  // Next-state, destination counters and source accumulators.
  // The accumulators track the position of the beat being presented, so
  // they only move on a transfer; a stall leaves everything untouched.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          dst_x_d = '0;
          dst_y_d = '0;
          acc_x_d = c_ACC_X0;
          acc_y_d = c_ACC_Y0;
          w_load  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_fire) begin
          if (eof_q) begin
            state_d = S_DONE;
            w_clear = 1'b1;
          end else if (eol_q) begin
            dst_x_d = '0;
            dst_y_d = dst_y_q + 10'd1;
            acc_x_d = c_ACC_X0;
            acc_y_d = acc_y_q + c_STEP_Y;
            w_load  = 1'b1;
          end else begin
            dst_x_d = dst_x_q + 11'd1;
            acc_x_d = acc_x_q + c_STEP_X;
            w_load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Single pulse cycle; a start seen here is deliberately dropped.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Negative positions (first pixel/line only) clamp to integer 0, fraction 0.
  assign w_x_neg = acc_x_d[15];
  assign w_y_neg = acc_y_d[15];
  assign w_src_x = w_x_neg ? 11'd0 : acc_x_d[15:5];
  assign w_src_y = w_y_neg ? 10'd0 : acc_y_d[14:5];
  assign w_dx    = w_x_neg ? 5'd0  : acc_x_d[4:0];
  assign w_dy    = w_y_neg ? 5'd0  : acc_y_d[4:0];

  // --------------------------------------------------------------------------
  // Beat register inputs. dxy is formed from the next-beat fractions so the
  // product lands in the same register stage as dx/dy.
  // --------------------------------------------------------------------------
  always_comb begin
    vld_d    = vld_q;
    src_x_d  = src_x_q;
    src_y_d  = src_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    dxy_d    = dxy_q;
    x_edge_d = x_edge_q;
    y_edge_d = y_edge_q;
    eol_d    = eol_q;
    eof_d    = eof_q;
    if (w_load) begin
      vld_d    = 1'b1;
      src_x_d  = w_src_x;
      src_y_d  = w_src_y;
      dx_d     = w_dx;
      dy_d     = w_dy;
      dxy_d    = {5'd0, w_dx} * {5'd0, w_dy};
      x_edge_d = (w_src_x == c_EDGE_X);
      y_edge_d = (w_src_y == c_EDGE_Y);
      eol_d    = (dst_x_d == c_LAST_X);
      eof_d    = (dst_x_d == c_LAST_X) && (dst_y_d == c_LAST_Y);
    end else if (w_clear) begin
      vld_d    = 1'b0;
      src_x_d  = '0;
      src_y_d  = '0;
      dx_d     = '0;
      dy_d     = '0;
      dxy_d    = '0;
      x_edge_d = 1'b0;
      y_edge_d = 1'b0;
      eol_d    = 1'b0;
      eof_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dst_x_q  <= '0;
      dst_y_q  <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      vld_q    <= 1'b0;
      src_x_q  <= '0;
      src_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      dxy_q    <= '0;
      x_edge_q <= 1'b0;
      y_edge_q <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      vld_q    <= vld_d;
      src_x_q  <= src_x_d;
      src_y_q  <= src_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      dxy_q    <= dxy_d;
      x_edge_q <= x_edge_d;
      y_edge_q <= y_edge_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
    end
  end

  assign busy_o         = (state_q == S_RUN);
  assign frame_done_o   = (state_q == S_DONE);

  assign out_if.out_vld = vld_q;
  assign out_if.src_x   = src_x_q;
  assign out_if.src_y   = src_y_q;
  assign out_if.dx      = dx_q;
  assign out_if.dy      = dy_q;
  assign out_if.dxy     = dxy_q;
  assign out_if.x_edge  = x_edge_q;
  assign out_if.y_edge  = y_edge_q;
  assign out_if.out_eol = eol_q;
  assign out_if.out_eof = eof_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_up_dxdy.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_up_dxdy
// Purpose  : Scoreboard bench for vga_up_dxdy on a reduced 32x12 -> 24x9
//            geometry that keeps the 4:3 ratio and step of 24/32, so the
//            fraction pattern and edge values match the full-size frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_up_dxdy;

  localparam int DST_W  = 32;
  localparam int DST_H  = 12;
  localparam int SRC_W  = 24;
  localparam int SRC_H  = 9;
  localparam int STEP_X = 24;
  localparam int STEP_Y = 24;
  localparam int NBEATS = DST_W * DST_H;

  typedef struct packed {
    logic [10:0] sx;
    logic [9:0]  sy;
    logic [4:0]  dx;
    logic [4:0]  dy;
    logic [9:0]  dxy;
    logic        xe;
    logic        ye;
    logic        eol;
    logic        eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;

  vga_up_dxdy_if vif ();

  vga_up_dxdy #(
    .DST_W (DST_W),
    .DST_H (DST_H),
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .STEP_X(STEP_X),
    .STEP_Y(STEP_Y)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .out_if      (vif)
  );

  always #5 clk = ~clk;

  beat_t cur;
  assign cur = {vif.src_x, vif.src_y, vif.dx, vif.dy, vif.dxy,
                vif.x_edge, vif.y_edge, vif.out_eol, vif.out_eof};

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    xfer_cnt = 0;
  int    sx5[5]   = '{0, 0, 1, 2, 2};
  int    dx5[5]   = '{0, 20, 12, 4, 28};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: source position from the centre-alignment rule, then split.
  function automatic beat_t model(input int x, input int y);
    beat_t b;
    int sx, sy, ix, fx, iy, fy;
    sx = STEP_X * x + STEP_X / 2 - 16;
    sy = STEP_Y * y + STEP_Y / 2 - 16;
    if (sx < 0) begin ix = 0; fx = 0; end else begin ix = sx / 32; fx = sx % 32; end
    if (sy < 0) begin iy = 0; fy = 0; end else begin iy = sy / 32; fy = sy % 32; end
    b.sx  = 11'(ix);
    b.sy  = 10'(iy);
    b.dx  = 5'(fx);
    b.dy  = 5'(fy);
    b.dxy = 10'(fx * fy);
    b.xe  = (ix == SRC_W - 1);
    b.ye  = (iy == SRC_H - 1);
    b.eol = (x == DST_W - 1);
    b.eof = (x == DST_W - 1) && (y == DST_H - 1);
    return b;
  endfunction

  // Hand-derived values at the points of interest in a frame.
  task automatic directed(input int i, input beat_t c);
    if (i < 5) begin
      chk($sformatf("first%0d_src_x", i), 64'(c.sx), 64'(sx5[i]));
      chk($sformatf("first%0d_dx", i), 64'(c.dx), 64'(dx5[i]));
      chk($sformatf("first%0d_src_y_dy", i), 64'({c.sy, c.dy}), 64'(0));
    end
    if (i == DST_W - 1) begin
      chk("eol_src_x", 64'(c.sx), 64'(SRC_W - 1));
      chk("eol_dx", 64'(c.dx), 64'(4));
      chk("eol_flags_xe_eol", 64'({c.xe, c.eol}), 64'(3));
    end
    if (i == DST_W) begin
      chk("line1_start_sx_dx_sy", 64'({c.sx, c.dx, c.sy}), 64'(0));
      chk("line1_start_dy", 64'(c.dy), 64'(20));
    end
    if (i == DST_W + 2) chk("dxy_2_1", 64'({c.dx, c.dy, c.dxy}), 64'({5'd12, 5'd20, 10'd240}));
    if (i == 2 * DST_W + 3) chk("dxy_3_2", 64'({c.dx, c.dy, c.dxy}), 64'({5'd4, 5'd12, 10'd48}));
    if (i == NBEATS - 1) begin
      chk("eof_src", 64'({c.sx, c.sy}), 64'({11'(SRC_W - 1), 10'(SRC_H - 1)}));
      chk("eof_frac", 64'({c.dx, c.dy, c.dxy}), 64'({5'd4, 5'd4, 10'd16}));
      chk("eof_flags_ye_eof", 64'({c.ye, c.eof}), 64'(3));
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability
  // and the frame-end sequence.
  initial begin
    beat_t snap;
    beat_t e;
    bit stall_prev = 1'b0;
    bit eof_prev   = 1'b0;
    bit done_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        xfer_cnt   = 0;
        stall_prev = 1'b0;
        eof_prev   = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (done_prev) begin
          chk("frame_done_single", 64'(frame_done), 64'(0));
          done_prev = 1'b0;
        end
        if (eof_prev) begin
          chk("post_eof_vld_done_busy", 64'({vif.out_vld, frame_done, busy}), 64'(3'b010));
          eof_prev  = 1'b0;
          done_prev = 1'b1;
        end
        if (stall_prev) begin
          chk("stall_vld", 64'(vif.out_vld), 64'(1));
          chk("stall_hold", 64'(cur), 64'(snap));
        end
        stall_prev = 1'b0;
        if (vif.out_vld && !vif.out_rdy) begin
          stall_prev = 1'b1;
          snap       = cur;
        end
        if (vif.out_vld && vif.out_rdy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL beat_unexpected: got beat 0x%0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", xfer_cnt), 64'(cur), 64'(e));
          end
          directed(xfer_cnt, cur);
          xfer_cnt++;
          if (xfer_cnt == NBEATS) eof_prev = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    for (int y = 0; y < DST_H; y++)
      for (int x = 0; x < DST_W; x++)
        exp_q.push_back(model(x, y));
    xfer_cnt = 0;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    chk("start_busy_vld", 64'({busy, vif.out_vld}), 64'(3));
  endtask

  task automatic wait_done(input bit rand_rdy);
    for (int i = 0; i < 3 * NBEATS + 50; i++) begin
      if (frame_done) break;
      if (rand_rdy) vif.out_rdy = 1'($urandom_range(0, 1));
      cyc(1);
    end
    chk("frame_done_seen", 64'(frame_done), 64'(1));
    chk("beat_count", 64'(xfer_cnt), 64'(NBEATS));
    vif.out_rdy = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    vif.out_rdy = 1'b0;
    cyc(3);
    chk("reset_outputs", 64'({vif.out_vld, busy, frame_done, cur}), 64'(0));
    rst = 1'b0;
    cyc(2);
    chk("idle_outputs", 64'({vif.out_vld, busy, frame_done, cur}), 64'(0));

    // Frame 1: full rate, one 5-cycle stall mid-line, start pulsed while busy.
    vif.out_rdy = 1'b1;
    do_start();
    cyc(10);
    vif.out_rdy = 1'b0;
    cyc(5);
    vif.out_rdy = 1'b1;
    cyc(7);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(1'b0);

    // Frame 2: random backpressure across the whole frame.
    do_start();
    wait_done(1'b1);

    // Frame 3: asynchronous reset mid-frame, then a clean restart.
    do_start();
    cyc(100);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({vif.out_vld, busy, frame_done, cur}), 64'(0));
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("post_reset_idle", 64'({vif.out_vld, busy}), 64'(0));
    do_start();
    wait_done(1'b0);

    cyc(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_up_dxdy.md
# vga_up_dxdy

Coordinate and bilinear-coefficient generator for the 960x540 -> 1280x720 upscale path in ZOOM, the reverse direction of the 1280x720 -> 960x540 downscale. For each destination pixel, in raster order, it emits:
- the top-left source pixel (src_x, src_y) of its 2x2 neighbourhood;
- 5-bit fractional weights dx, dy and their product dxy;
- edge and line/frame markers.

Output uses a valid/ready stream, so the frame-buffer reader and interpolator can stall it freely.

## Interface
- DST_W, 1280: destination pixels per line
- DST_H, 720: destination lines per frame
- SRC_W, 960: source pixels per line
- SRC_H, 540: source lines per frame
- STEP_X, 24: horizontal source step per destination pixel in 1/32 units (32*SRC_W/DST_W)
- STEP_Y, 24: vertical source step per destination line in 1/32 units (32*SRC_H/DST_H)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame start pulse; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until frame_done
- out_vld  out  1  beat valid
- out_rdy  in  1  downstream ready; a beat transfers when out_vld & out_rdy
- src_x  out  11  integer source column
- src_y  out  10  integer source row
- dx  out  5  horizontal fraction, units of 1/32
- dy  out  5  vertical fraction, units of 1/32
- dxy  out  10  dx*dy, unsigned, same beat
- x_edge  out  1  src_x == SRC_W-1; right neighbour = src_x
- y_edge  out  1  src_y == SRC_H-1; lower neighbour = src_y
- out_eol  out  1  beat is the last pixel of a line
- out_eof  out  1  beat is the last pixel of the frame
- frame_done  out  1  single-cycle pulse after the last beat transfers

## Operation
- Destination counters: dst_x in 0..DST_W-1, dst_y in 0..DST_H-1. dst_x advances per transfer; dst_y advances on the eol transfer.
- Source position in 1/32 units: s = STEP*dst + STEP/2 - 16. With defaults, s = 24*dst - 4.
- s is held in signed accumulators acc_x, acc_y (16 bits), with no multiplier:
  - acc_x loads STEP_X/2-16 at line start and adds STEP_X per transfer;
  - acc_y loads STEP_Y/2-16 at frame start and adds STEP_Y per line.
- Clamp: a negative accumulator value produces integer 0 and fraction 0. With defaults this happens only at dst=0.
- Integer part = acc[15:5]; fraction = acc[4:0].
- dxy = dx*dy, computed from the next-beat values and registered together with the rest of the beat, so all fields are aligned.
- FSM:
  - IDLE: start=1 -> RUN, counters and accumulators initialised.
  - RUN: on the eof transfer -> DONE.
  - DONE: one cycle; frame_done=1, busy=0; -> IDLE.
  - start during DONE is ignored. A new frame may start from the following cycle (IDLE).
- Horizontal fraction cycles 0,20,12,4,28,20,12,4,... and src_x steps 0,0,1,2,2,3,4,5,5,... (period 4 dst / 3 src).

## Timing
- Reset: IDLE; every output is 0, including out_vld, busy and frame_done.
- start accepted at cycle N -> busy=1 and out_vld=1 at N+1 carrying dst (0,0).
- Throughput: 1 beat per cycle while out_rdy=1. A frame is exactly DST_W*DST_H = 921600 transfers.
- While out_vld=1 and out_rdy=0, every output field holds stable; no beat is dropped or repeated.
- On the eof transfer at cycle M: out_vld=0 and frame_done=1 at M+1; busy=0 from M+1.
- Reset asserted mid-frame: all outputs clear asynchronously and the FSM returns to IDLE. The next start restarts at (0,0).
- out_vld is never deasserted without a transfer.

## Test plan
- Reset, start, out_rdy=1. First five beats must read:
  - (src_x,dx) = (0,0), (0,20), (1,12), (2,4), (2,28);
  - src_y=0 and dy=0 on all five;
  - out_vld high from the cycle after start.
- Line boundary:
  - beat dst_x=1279: src_x=959, dx=4, x_edge=1, out_eol=1;
  - next beat: src_x=0, dx=0, src_y=0, dy=20.
- dxy check: at dst (2,1), dx=12, dy=20, dxy=240. At dst (3,2), dx=4, dy=12, dxy=48.
- Backpressure:
  - hold out_rdy=0 for 5 cycles mid-line: all outputs frozen;
  - toggle out_rdy randomly over a full frame: the sequence is identical to the out_rdy=1 run (compare against a golden model).
- Frame end:
  - beat (1279,719): src_x=959, src_y=539, dx=4, dy=4, dxy=16, y_edge=1, out_eof=1;
  - next cycle: out_vld=0, frame_done=1 for one cycle, busy=0;
  - beat count = 921600.
- Control corner cases:
  - start pulsed while busy: no effect;
  - rst pulsed mid-frame: outputs are 0 immediately; a subsequent start yields first beat (0,0,dx=0,dy=0).
